// File: rtl/uart_io_pkg.sv
// Shared register map and status-bit layout for the UART receive FIFO IO block.
package uart_io_pkg;

  localparam logic OFF_DATA   = 1'b0;
  localparam logic OFF_STATUS = 1'b1;

  localparam int unsigned ST_NOT_EMPTY = 0;
  localparam int unsigned ST_FULL      = 1;
  localparam int unsigned ST_OVERFLOW  = 2;
  localparam int unsigned ST_FLUSH     = 3;

  localparam int unsigned DATA_VALID   = 8;

  function automatic logic [31:0] fmt_status(input logic [7:0] cnt,
                                             input logic       overflow,
                                             input logic       full,
                                             input logic       not_empty);
    logic [31:0] word;
    word               = '0;
    word[15:8]         = cnt;
    word[ST_OVERFLOW]  = overflow;
    word[ST_FULL]      = full;
    word[ST_NOT_EMPTY] = not_empty;
    return word;
  endfunction

endpackage

// File: rtl/sync_fifo_byte.sv
// Single-clock byte FIFO with push, pop and flush; pop on empty and push on
// full (without a coincident pop) are ignored.
module sync_fifo_byte #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  push,
  input  logic [7:0]            din,
  input  logic                  pop,
  output logic [7:0]            dout,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  // count never exceeds DEPTH, so its top bit alone marks full
  assign full  = count[DEPTH_LOG2];
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // a pop on a full FIFO frees the slot the coincident push lands in
  assign do_pop  = resetn & ~flush & pop & ~empty;
  assign do_push = resetn & ~flush & push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (do_pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (DEPTH_LOG2+1)'(1);
        2'b01:   count <= count - (DEPTH_LOG2+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo_io.sv
// Memory-mapped IO responder buffering UART receive bytes: DATA read pops
// (bit 8 = valid), STATUS read/write exposes count, full, overflow and flush.
module uart_rx_fifo_io
  import uart_io_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sel,
  input  logic        reg_off,
  input  logic        mem_rstrb,
  input  logic [3:0]  mem_wmask,
  input  logic [31:0] mem_wdata,
  output logic [31:0] rdata,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic        rx_irq
);

  logic                rd_acc;
  logic                status_wr;
  logic                pop;
  logic                flush;
  logic                ovf_clr;
  logic                ovf_set;
  logic                overflow;
  logic [7:0]          head;
  logic [DEPTH_LOG2:0] count;
  logic                full;
  logic                empty;
  logic [31:0]         rd_val;
  logic                unused_wdata;

  assign unused_wdata = ^{mem_wdata[31:4], mem_wdata[1:0]};

  assign rd_acc    = sel & mem_rstrb;
  assign status_wr = sel & (|mem_wmask) & (reg_off == OFF_STATUS);
  assign pop       = rd_acc & (reg_off == OFF_DATA);
  assign flush     = status_wr & mem_wdata[ST_FLUSH];
  assign ovf_clr   = status_wr & mem_wdata[ST_OVERFLOW];
  // a drop happens only when full with no pop freeing a slot; flush discards silently
  assign ovf_set   = rx_valid & full & ~pop & ~flush;

  sync_fifo_byte #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .flush  (flush),
    .push   (rx_valid),
    .din    (rx_byte),
    .pop    (pop),
    .dout   (head),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  always_comb begin
    rd_val = '0;
    if (reg_off == OFF_DATA) begin
      if (!empty) begin
        rd_val[7:0]       = head;
        rd_val[DATA_VALID] = 1'b1;
      end
    end else begin
      rd_val = fmt_status(8'(count), overflow, full, ~empty);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      overflow <= 1'b0;
      rdata    <= '0;
      rx_irq   <= 1'b0;
    end else begin
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
      rx_irq <= ~empty;
      if (rd_acc) rdata <= rd_val;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo_io.sv
// Directed self-checking bench for uart_rx_fifo_io with hand-computed expectations.
module tb_uart_rx_fifo_io;

  logic        clk;
  logic        resetn;
  logic        sel;
  logic        reg_off;
  logic        mem_rstrb;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] rdata;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        rx_irq;

  int unsigned n_cmp;
  int unsigned n_err;

  uart_rx_fifo_io #(.DEPTH_LOG2(4)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .sel       (sel),
    .reg_off   (reg_off),
    .mem_rstrb (mem_rstrb),
    .mem_wmask (mem_wmask),
    .mem_wdata (mem_wdata),
    .rdata     (rdata),
    .rx_valid  (rx_valid),
    .rx_byte   (rx_byte),
    .rx_irq    (rx_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sel = 1'b0; mem_rstrb = 1'b0; mem_wmask = 4'h0; mem_wdata = '0;
    reg_off = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_valid = 1'b1; rx_byte = b;
    cyc();
    idle();
  endtask

  task automatic bus_read(input logic off, input logic psh, input logic [7:0] b);
    sel = 1'b1; mem_rstrb = 1'b1; reg_off = off; rx_valid = psh; rx_byte = b;
    cyc();
    idle();
  endtask

  task automatic bus_write(input logic off, input logic [31:0] d, input logic psh, input logic [7:0] b);
    sel = 1'b1; mem_wmask = 4'hF; mem_wdata = d; reg_off = off; rx_valid = psh; rx_byte = b;
    cyc();
    idle();
  endtask

  localparam logic DAT = 1'b0;
  localparam logic STA = 1'b1;

  initial begin
    logic [7:0] prev;
    logic [7:0] cur;
    n_cmp = 0;
    n_err = 0;
    idle();
    resetn = 1'b0;
    cyc(); cyc();
    resetn = 1'b1;
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_irq", {31'b0, rx_irq}, 32'h0);
    bus_read(STA, 1'b0, 8'h00);
    chk("reset_status", rdata, 32'h0);

    // single byte
    push_byte(8'h41);
    cyc(); cyc();
    chk("irq_after_push", {31'b0, rx_irq}, 32'h1);
    bus_read(DAT, 1'b0, 8'h00);
    chk("read_41", rdata, 32'h0000_0141);
    cyc(); cyc();
    chk("irq_after_pop", {31'b0, rx_irq}, 32'h0);
    bus_read(DAT, 1'b0, 8'h00);
    chk("read_empty", rdata, 32'h0);

    // fill to full, then overflow
    for (int i = 0; i < 16; i++) push_byte(8'(8'h10 + i));
    bus_read(STA, 1'b0, 8'h00);
    chk("status_full", rdata, 32'h0000_1003);
    push_byte(8'h99);
    bus_read(STA, 1'b0, 8'h00);
    chk("status_ovf", rdata, 32'h0000_1007);
    bus_write(STA, 32'h4, 1'b0, 8'h00);
    bus_read(STA, 1'b0, 8'h00);
    chk("ovf_cleared", rdata, 32'h0000_1003);

    // push while full with coincident pop
    bus_read(DAT, 1'b1, 8'hAA);
    chk("full_pop_push", rdata, 32'h0000_0110);
    bus_read(STA, 1'b0, 8'h00);
    chk("full_pop_push_status", rdata, 32'h0000_1003);
    for (int i = 1; i < 16; i++) begin
      bus_read(DAT, 1'b0, 8'h00);
      chk("drain", rdata, 32'h0000_0100 | 32'(8'h10 + i));
    end
    bus_read(DAT, 1'b0, 8'h00);
    chk("drain_aa_last", rdata, 32'h0000_01AA);
    bus_read(STA, 1'b0, 8'h00);
    chk("drained_status", rdata, 32'h0);

    // overflow set beats clear; flush beats push and leaves overflow alone
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    bus_write(STA, 32'h4, 1'b1, 8'h77);
    bus_read(STA, 1'b0, 8'h00);
    chk("set_wins", rdata, 32'h0000_1007);
    bus_write(STA, 32'h8, 1'b1, 8'h88);
    bus_read(STA, 1'b0, 8'h00);
    chk("flush_wins", rdata, 32'h0000_0004);
    bus_write(STA, 32'h4, 1'b0, 8'h00);
    bus_read(STA, 1'b0, 8'h00);
    chk("ovf_clear2", rdata, 32'h0);

    // flush with 5 queued
    for (int i = 0; i < 5; i++) push_byte(8'(8'h30 + i));
    bus_read(STA, 1'b0, 8'h00);
    chk("five_queued", rdata, 32'h0000_0501);
    bus_write(STA, 32'h8, 1'b0, 8'h00);
    bus_read(STA, 1'b0, 8'h00);
    chk("flush_status", rdata, 32'h0);
    cyc(); cyc();
    chk("flush_irq", {31'b0, rx_irq}, 32'h0);

    // empty read with coincident push
    bus_read(DAT, 1'b1, 8'h55);
    chk("empty_read_push", rdata, 32'h0);
    bus_read(DAT, 1'b0, 8'h00);
    chk("read_55", rdata, 32'h0000_0155);

    // DATA write ignored; deselected access has no effect
    push_byte(8'h66);
    bus_write(DAT, 32'hFFFF_FFFF, 1'b0, 8'h00);
    sel = 1'b0; mem_rstrb = 1'b1; reg_off = DAT;
    cyc();
    idle();
    chk("nosel_rdata_holds", rdata, 32'h0000_0155);
    sel = 1'b0; mem_wmask = 4'hF; mem_wdata = 32'h8; reg_off = STA;
    cyc();
    idle();
    bus_read(STA, 1'b0, 8'h00);
    chk("nosel_no_flush", rdata, 32'h0000_0101);
    bus_read(DAT, 1'b0, 8'h00);
    chk("read_66", rdata, 32'h0000_0166);

    // reset mid-operation
    for (int i = 0; i < 3; i++) push_byte(8'(8'hC0 + i));
    resetn = 1'b0;
    cyc();
    resetn = 1'b1;
    chk("midreset_rdata", rdata, 32'h0);
    chk("midreset_irq", {31'b0, rx_irq}, 32'h0);
    bus_read(STA, 1'b0, 8'h00);
    chk("midreset_status", rdata, 32'h0);

    // pointer wrap: 40 simultaneous push/pop pairs with one byte in flight
    prev = 8'd5;
    push_byte(prev);
    for (int i = 1; i <= 40; i++) begin
      cur = 8'((i * 37 + 5) & 8'hFF);
      bus_read(DAT, 1'b1, cur);
      chk("wrap", rdata, 32'h0000_0100 | 32'(prev));
      prev = cur;
    end
    bus_read(DAT, 1'b0, 8'h00);
    chk("wrap_last", rdata, 32'h0000_0100 | 32'(prev));
    bus_read(STA, 1'b0, 8'h00);
    chk("wrap_status", rdata, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo_io.md
Name: uart_rx_fifo_io

Overview:
- Memory-mapped IO responder that buffers bytes from the UART receiver in a FIFO so the processor can read them at its own pace.
- Without it, the receiver's one-cycle valid pulse is lost whenever the CPU is not polling.
- Sits on the IO page of the SoC memory bus, answering processor load and store strobes.
- The SoC decodes the IO page and one-hot word bit and supplies sel; this block decodes only the 1-bit register offset.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth (DEPTH = 16 bytes).

Ports:
- clk  input  1  system clock
- resetn  input  1  synchronous, active-low reset
- sel  input  1  bus access targets this block (IO page and block word bit, pre-decoded by SoC)
- reg_off  input  1  register offset: 0 = DATA, 1 = STATUS
- mem_rstrb  input  1  processor read strobe
- mem_wmask  input  4  processor byte write mask; any bit set = write
- mem_wdata  input  32  write data
- rdata  output  32  registered read data
- rx_valid  input  1  one-cycle pulse from UART receiver: byte valid
- rx_byte  input  8  received byte, valid when rx_valid = 1
- rx_irq  output  1  level: FIFO not empty

Behaviour:
- Reset (resetn = 0 at a clk edge):
  - Read and write pointers, count and overflow flag cleared to 0.
  - rdata = 0; rx_irq = 0.
  - Reset overrides any access or push in the same cycle.
  - Reset mid-operation discards all buffered bytes.
- Read timing:
  - rdata is registered on the cycle where sel & mem_rstrb = 1.
  - It is valid the next cycle (1-cycle latency, matching RAM).
  - rdata holds its value until the next read strobe to this block.
- DATA read (reg_off = 0):
  - Not empty: rdata = {23'b0, 1'b1, head byte}; read pointer increments; count decrements.
  - Empty: rdata = 0; no pointer change.
  - Bit 8 is the valid flag, so a single load both polls and pops.
- STATUS read (reg_off = 1), no side effects:
  - rdata = {16'b0, count[7:0] zero-extended, 5'b0, overflow, full, not_empty}.
  - Bit positions: bit0 not_empty, bit1 full, bit2 overflow, bits[15:8] count.
- STATUS write (sel & |mem_wmask & reg_off = 1):
  - mem_wdata[2] = 1 clears overflow.
  - mem_wdata[3] = 1 flushes: pointers and count to 0.
  - Other bits ignored.
- DATA write: ignored.
- Push (rx_valid = 1):
  - Not full: store rx_byte at the write pointer; write pointer increments.
  - Full with no pop in the same cycle: byte dropped; overflow set (sticky).
- Simultaneous push and pop:
  - Both performed; count unchanged.
  - When full, the push is accepted because the pop frees the slot; overflow is not set.
  - When empty, the DATA read returns 0; the push is still stored; count becomes 1.
- Simultaneous flush and push: flush wins, byte discarded, overflow unchanged.
- Simultaneous overflow-clear and overflow event: set wins.
- Pointers are DEPTH_LOG2 bits and wrap modulo DEPTH.
- count is DEPTH_LOG2+1 bits, range 0..DEPTH.
  - full = (count == DEPTH); not_empty = (count != 0).
- rx_irq = not_empty, registered, and follows count the cycle after it changes.
- Bus access with sel = 0: no effect; rdata holds.
- mem_rstrb and |mem_wmask never coincide (processor guarantee).
- If they do: the read is serviced and the write is also applied.

Decomposition:
- Shared package uart_io_pkg holds:
  - offset constants OFF_DATA = 0, OFF_STATUS = 1;
  - status bit indices ST_NOT_EMPTY = 0, ST_FULL = 1, ST_OVERFLOW = 2, ST_FLUSH = 3;
  - DATA valid bit index DATA_VALID = 8.
- One sub-module, sync_fifo_byte:
  - single-clock byte FIFO with push, pop and flush;
  - outputs count, full and empty;
  - pop on empty and push on full (without pop) are ignored.
- The top level adds bus decode, the overflow flag and rdata formatting.

Test Plan:
- Reset; single rx_valid with byte 0x41; read DATA -> rdata = 0x00000141; next DATA read -> 0x00000000; rx_irq goes 1 then 0.
- Push 0x10..0x1F (16 bytes) -> STATUS = 0x00001003; 17th push 0x99 -> STATUS = 0x00001007; 16 DATA reads return 0x110..0x11F in order.
- FIFO full, rx_valid 0xAA in the same cycle as a DATA read -> read returns 0x110; count stays 16; overflow stays 0; 0xAA is the last byte read.
- Overflow set; write STATUS 0x4 -> STATUS bit2 = 0; write STATUS 0x8 with 5 bytes queued -> STATUS = 0x00000000; rx_irq = 0.
- Empty FIFO, DATA read coincident with rx_valid 0x55 -> rdata = 0; next DATA read -> 0x00000155.
- 3 bytes queued, assert resetn = 0 for one cycle -> STATUS = 0, rdata = 0, rx_irq = 0; pointer wrap verified by 40 push/pop pairs with matching data.
